// File: rtl/spi_command_frontend.sv
// Host-command front-end: decodes a per-frame command byte, streams status,
// assembles fixed-size motion records and commits them to one of N channel FIFOs.
module spi_command_frontend #(
  parameter int Channels    = 4,
  parameter int RecordBytes = 12,
  parameter int FreeBits    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_cs,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_byte,
  input  logic [Channels*FreeBits-1:0] fifo_free,
  output logic [Channels-1:0]        fifo_wr_en,
  output logic [RecordBytes*8-1:0]   fifo_wr_data,
  output logic [Channels-1:0]        fifo_flush,
  output logic [7:0]                 error_flags
);

  localparam int BcW  = (RecordBytes > 1) ? $clog2(RecordBytes) : 1;
  localparam int ChW  = (Channels > 1) ? $clog2(Channels) : 1;
  localparam int IdxW = $clog2(Channels + 2);

  localparam logic [3:0] OP_STATUS = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_FLUSH  = 4'h2;
  localparam logic [3:0] OP_CLEAR  = 4'h3;

  typedef enum logic [1:0] {S_IDLE, S_STATUS, S_RECEIVE, S_DISCARD} state_t;

  state_t                   state_q, state_d;
  logic [BcW-1:0]           bc_q, bc_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [ChW-1:0]           ch_q, ch_d;
  logic [RecordBytes*8-1:0] rec_q, rec_d;
  logic [Channels-1:0]      wr_en_q, wr_en_d;
  logic [Channels-1:0]      flush_q, flush_d;
  logic [2:0]               err_q, err_d;
  logic [7:0]               tx_q, tx_d;

  logic [7:0]               free8 [Channels];
  logic [FreeBits-1:0]      ch_free;
  logic                     ch_ok;
  logic                     bad_cmd;

  // Status replies carry free counts resized to one byte.
  genvar gi;
  generate
    for (gi = 0; gi < Channels; gi++) begin : g_free
      if (FreeBits >= 8) begin : g_trunc
        assign free8[gi] = fifo_free[gi*FreeBits +: 8];
      end else begin : g_ext
        assign free8[gi] = {{(8-FreeBits){1'b0}}, fifo_free[gi*FreeBits +: FreeBits]};
      end
    end
  endgenerate

  assign ch_ok = (32'(rx_byte[3:0]) < Channels);

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    rec_d   = rec_q;
    wr_en_d = '0;
    flush_d = '0;
    err_d   = err_q;
    tx_d    = 8'h00;
    bad_cmd = 1'b0;
    ch_free = '0;
    for (int c = 0; c < Channels; c++) begin
      if (32'(ch_q) == c) ch_free = fifo_free[c*FreeBits +: FreeBits];
    end

    if (spi_cs) begin
      // Deselect aborts the frame; a half-built record is never committed.
      state_d = S_IDLE;
      bc_d    = '0;
      idx_d   = '0;
      if (state_q == S_RECEIVE && bc_q != '0) err_d[1] = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DISCARD;
          case (rx_byte[7:4])
            OP_STATUS: begin
              state_d = S_STATUS;
              idx_d   = '0;
            end
            OP_WRITE: begin
              if (ch_ok) begin
                state_d = S_RECEIVE;
                ch_d    = rx_byte[ChW-1:0];
                bc_d    = '0;
              end else begin
                bad_cmd = 1'b1;
              end
            end
            OP_FLUSH: begin
              if (ch_ok) begin
                for (int c = 0; c < Channels; c++) flush_d[c] = (32'(rx_byte[3:0]) == c);
              end else begin
                bad_cmd = 1'b1;
              end
            end
            OP_CLEAR: err_d = '0;
            default:  bad_cmd = 1'b1;
          endcase
          if (bad_cmd) err_d[2] = 1'b1;
        end
        S_STATUS: begin
          if (32'(idx_q) < Channels + 1) idx_d = idx_q + 1'b1;
        end
        S_RECEIVE: begin
          for (int k = 0; k < RecordBytes; k++) begin
            if (32'(bc_q) == k) rec_d[k*8 +: 8] = rx_byte;
          end
          if (bc_q == BcW'(RecordBytes - 1)) begin
            bc_d = '0;
            if (ch_free != '0) begin
              for (int c = 0; c < Channels; c++) wr_en_d[c] = (32'(ch_q) == c);
            end else begin
              err_d[0] = 1'b1;
            end
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Reply byte follows the state being entered, with the live free counts.
    case (state_d)
      S_IDLE: tx_d = free8[0];
      S_STATUS: begin
        for (int c = 0; c < Channels; c++) begin
          if (32'(idx_d) == c) tx_d = free8[c];
        end
        if (32'(idx_d) == Channels) tx_d = {5'b0, err_d};
      end
      default: tx_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bc_q    <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      rec_q   <= '0;
      wr_en_q <= '0;
      flush_q <= '0;
      err_q   <= '0;
      tx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      rec_q   <= rec_d;
      wr_en_q <= wr_en_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_byte      = tx_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = rec_q;
  assign fifo_flush   = flush_q;
  assign error_flags  = {5'b0, err_q};

endmodule

// File: tb/tb_spi_command_frontend.sv
// Randomised and directed bench for spi_command_frontend against a frame-level
// behavioural model of the host protocol.
module tb_spi_command_frontend;

  localparam int C  = 4;
  localparam int RB = 12;
  localparam int FB = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_cs = 1'b1;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_byte;
  logic [C*FB-1:0]   fifo_free = '0;
  logic [C-1:0]      fifo_wr_en;
  logic [RB*8-1:0]   fifo_wr_data;
  logic [C-1:0]      fifo_flush;
  logic [7:0]        error_flags;

  spi_command_frontend #(.Channels(C), .RecordBytes(RB), .FreeBits(FB)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .tx_byte(tx_byte), .fifo_free(fifo_free),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_flush(fifo_flush), .error_flags(error_flags)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;

  // Model: tracks the frame's command byte and collected payload bytes.
  logic [7:0]  fr [C];
  bit          m_have_cmd, m_status, m_writing;
  int          m_nstat, m_ch;
  logic [7:0]  m_rec [$];
  logic [7:0]  m_err;
  logic [C-1:0]    e_wr, e_flush;
  logic [RB*8-1:0] e_data;
  logic [7:0]      e_tx;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have_cmd = 0; m_status = 0; m_writing = 0;
    m_nstat = 0; m_ch = 0; m_rec.delete(); m_err = 8'h00;
    e_data = '0;
  endtask

  task automatic model_step(input logic cs, input logic v, input logic [7:0] b);
    int op, ch;
    e_wr = '0; e_flush = '0;
    if (cs) begin
      if (m_writing && m_rec.size() > 0) m_err[1] = 1'b1;
      m_have_cmd = 0; m_status = 0; m_writing = 0; m_rec.delete();
    end else if (v) begin
      if (!m_have_cmd) begin
        m_have_cmd = 1;
        op = int'(b[7:4]); ch = int'(b[3:0]);
        if (op == 0) begin m_status = 1; m_nstat = 0; end
        else if (op == 1 && ch < C) begin m_writing = 1; m_ch = ch; end
        else if (op == 2 && ch < C) e_flush[ch] = 1'b1;
        else if (op == 3) m_err = 8'h00;
        else m_err[2] = 1'b1;
      end else if (m_status) begin
        if (m_nstat < C + 1) m_nstat++;
      end else if (m_writing) begin
        m_rec.push_back(b);
        if (m_rec.size() == RB) begin
          if (fr[m_ch] != 0) begin
            e_wr[m_ch] = 1'b1;
            for (int k = 0; k < RB; k++) e_data[k*8 +: 8] = m_rec[k];
          end else begin
            m_err[0] = 1'b1;
          end
          m_rec.delete();
        end
      end
    end
    if (!m_have_cmd) e_tx = fr[0];
    else if (m_status) e_tx = (m_nstat < C) ? fr[m_nstat] : ((m_nstat == C) ? m_err : 8'h00);
    else e_tx = 8'h00;
  endtask

  task automatic cyc(input logic cs, input logic v, input logic [7:0] b);
    @(negedge clk);
    spi_cs = cs; rx_valid = v; rx_byte = b;
    fifo_free = {fr[3], fr[2], fr[1], fr[0]};
    model_step(cs, v, b);
    @(posedge clk);
    #1;
    chk("tx", tx_byte, e_tx);
    chk("wr_en", fifo_wr_en, e_wr);
    chk("flush", fifo_flush, e_flush);
    chk("err", error_flags, m_err);
    if (e_wr != '0) chk("wr_data", fifo_wr_data, e_data);
    if (fifo_wr_en != '0) n_wr++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx"}, tx_byte, 8'h00);
    chk({tag, "_wr"}, fifo_wr_en, '0);
    chk({tag, "_fl"}, fifo_flush, '0);
    chk({tag, "_err"}, error_flags, 8'h00);
    chk({tag, "_data"}, fifo_wr_data, '0);
  endtask

  initial begin
    logic [7:0] st_exp [6];
    logic [7:0] cmd;
    int w0, len;
    st_exp = '{8'h10, 8'h07, 8'h03, 8'h00, 8'h00, 8'h00};
    fr[0] = 8'd16; fr[1] = 8'd16; fr[2] = 8'd7; fr[3] = 8'd3;
    fifo_free = {fr[3], fr[2], fr[1], fr[0]};
    model_reset();

    // Reset state.
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 8'h00);
    chk("rst_tx10", tx_byte, 8'h10);
    $display("txn reset released tx=%02h", tx_byte);

    // Status frame.
    cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h00);
    chk("st_cmd", tx_byte, 8'h10);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 8'hA5);
      chk("st_seq", tx_byte, st_exp[i]);
    end
    cyc(1, 0, 8'h00);
    $display("txn status frame done");

    // Two back-to-back records to channel 2.
    fr[2] = 8'd5;
    w0 = n_wr;
    cyc(0, 1, 8'h12);
    for (int i = 0; i < 24; i++) begin
      cyc(0, 1, 8'(i));
      if (i == 11) begin
        chk("w1_en", fifo_wr_en, 4'b0100);
        chk("w1_b0", fifo_wr_data[7:0], 8'h00);
        chk("w1_b11", fifo_wr_data[95:88], 8'h0B);
      end
      if (i == 23) begin
        chk("w2_en", fifo_wr_en, 4'b0100);
        chk("w2_b0", fifo_wr_data[7:0], 8'h0C);
      end
    end
    cyc(1, 0, 8'h00);
    chk("w_cnt", n_wr - w0, 2);
    chk("w_err", error_flags, 8'h00);
    $display("txn write 2 records ch2");

    // Overflow on channel 1.
    fr[1] = 8'd0;
    w0 = n_wr;
    cyc(0, 1, 8'h11);
    for (int i = 0; i < RB; i++) cyc(0, 1, 8'($urandom_range(0, 255)));
    cyc(1, 0, 8'h00);
    chk("ov_cnt", n_wr - w0, 0);
    chk("ov_err", error_flags, 8'h01);
    $display("txn overflow ch1 err=%02h", error_flags);

    // Partial record then status readback of the error byte.
    w0 = n_wr;
    cyc(0, 1, 8'h10);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(i + 8'h40));
    cyc(1, 0, 8'h00);
    chk("pa_cnt", n_wr - w0, 0);
    chk("pa_bit1", error_flags[1], 1'b1);
    cyc(0, 1, 8'h00);
    for (int i = 0; i < C; i++) cyc(0, 1, 8'hFF);
    chk("pa_stat", tx_byte, 8'h03);
    cyc(1, 0, 8'h00);
    $display("txn partial frame err=%02h", error_flags);

    // Bad command, flush, clear.
    cyc(0, 1, 8'h14);
    chk("bad_bit2", error_flags[2], 1'b1);
    chk("bad_wr", fifo_wr_en, 4'b0000);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h23);
    chk("fl_on", fifo_flush, 4'b1000);
    cyc(0, 1, 8'h55);
    chk("fl_off", fifo_flush, 4'b0000);
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h30);
    chk("clr", error_flags, 8'h00);
    cyc(1, 0, 8'h00);
    $display("txn bad/flush/clear done");

    // Deselect coinciding with the final byte of a record.
    fr[0] = 8'd9;
    w0 = n_wr;
    cyc(0, 1, 8'h10);
    for (int i = 0; i < RB - 1; i++) cyc(0, 1, 8'(i));
    cyc(1, 1, 8'hAA);
    chk("cs_wr", fifo_wr_en, 4'b0000);
    chk("cs_err", error_flags, 8'h02);
    chk("cs_idle", tx_byte, 8'd9);
    chk("cs_cnt", n_wr - w0, 0);
    $display("txn cs override err=%02h", error_flags);

    // Randomised frames.
    for (int f = 0; f < 200; f++) begin
      for (int c = 0; c < C; c++)
        fr[c] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      case ($urandom_range(0, 9))
        0, 1, 2:    cmd = {4'h0, 4'($urandom_range(0, 15))};
        3, 4, 5, 6: cmd = {4'h1, 4'($urandom_range(0, C))};
        7:          cmd = {4'h2, 4'($urandom_range(0, C + 1))};
        8:          cmd = {4'h3, 4'($urandom_range(0, 15))};
        default:    cmd = 8'($urandom_range(0, 255));
      endcase
      len = $urandom_range(0, 30);
      cyc(0, 0, 8'h00);
      cyc(0, 1, cmd);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) cyc(0, 0, 8'h00);
        if ($urandom_range(0, 7) == 0) fr[$urandom_range(0, C - 1)] = 8'($urandom_range(0, 255));
        cyc(0, 1, 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) == 0) cyc(1, 1, 8'($urandom_range(0, 255)));
      else cyc(1, 0, 8'h00);
      $display("txn frame %0d cmd=%02h len=%0d err=%02h", f, cmd, len, error_flags);
    end

    // Asynchronous reset in the middle of a record.
    fr[0] = 8'd12;
    cyc(0, 1, 8'h10);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(i));
    @(negedge clk);
    spi_cs = 1'b1; rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1, 0, 8'h00);
    chk("mid_nopartial", error_flags, 8'h00);
    $display("txn mid-frame reset err=%02h", error_flags);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_command_frontend.md
# spi_command_frontend

Parametrised host-command front-end between the SPI byte shifter and N per-axis motion-segment FIFOs. Decodes a command byte at the start of every chip-select frame and either streams back FIFO free-slot counts and sticky error flags, assembles whole motion-segment records and commits them to a selected channel FIFO, flushes a channel, or clears errors. It generalises the single-channel idle/receive front-end to multiple channels. Only complete records are ever written, so a truncated frame can never corrupt FIFO alignment.

## Interface

Parameters:
- Channels, 4: number of motion FIFOs. Legal range 1..16.
- RecordBytes, 12: bytes per motion-segment record. Must be ≥1.
- FreeBits, 8: width of each free-slot count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- spi_cs  in  1  chip select, high = deselected. Already synchronised to clk.
- rx_byte  in  8  byte received from the host.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- tx_byte  out  8  registered byte presented to the shifter for the next transfer.
- fifo_free  in  Channels*FreeBits  free record slots per channel. Channel c occupies bits [c*FreeBits +: FreeBits].
- fifo_wr_en  out  Channels  one-hot, one-cycle record write strobe.
- fifo_wr_data  out  RecordBytes*8  assembled record. Byte k occupies bits [8k+7:8k].
- fifo_flush  out  Channels  one-hot, one-cycle flush strobe.
- error_flags  out  8  sticky errors: bit0 OVERFLOW, bit1 PARTIAL, bit2 BAD_CMD, bits 7:3 = 0.

## Operation

- Command byte = {op[7:4], ch[3:0]}.
  - op 0x0 = STATUS (ch ignored).
  - op 0x1 = WRITE.
  - op 0x2 = FLUSH.
  - op 0x3 = CLEAR_ERRORS.
- States: IDLE, STATUS, RECEIVE, DISCARD.
- All transitions require rx_valid=1 and spi_cs=0, except where noted.
- IDLE:
  - STATUS → STATUS; status index idx <= 0.
  - WRITE with ch < Channels → RECEIVE; latch ch; byte counter bc <= 0.
  - FLUSH with ch < Channels → fifo_flush[ch] pulses the next cycle; → DISCARD.
  - CLEAR_ERRORS → error_flags <= 0; → DISCARD.
  - Any other op, or ch ≥ Channels → set BAD_CMD; → DISCARD.
- STATUS: each rx_valid increments idx. idx saturates at Channels+1.
- RECEIVE:
  - Each rx_valid stores rx_byte at byte position bc, then bc increments.
  - On the byte with bc = RecordBytes-1, fifo_free[ch] is sampled in the same cycle.
    - If non-zero: fifo_wr_en[ch] pulses the next cycle with the full record on fifo_wr_data.
    - If zero: the record is dropped and OVERFLOW is set.
  - Either way bc wraps to 0, so several records may be sent per frame.
- DISCARD: all further bytes of the frame are ignored.
- spi_cs=1 in any state:
  - state <= IDLE on the next edge; spi_cs=1 overrides a coincident rx_valid.
  - If leaving RECEIVE with bc ≠ 0, the partial record is discarded, PARTIAL is set, and nothing is written.
- tx_byte, updated every cycle:
  - IDLE: free count of channel 0 (backward compatible with the single-channel status reply).
  - STATUS: idx < Channels → free[idx]; idx = Channels → error_flags; otherwise 0x00.
  - RECEIVE/DISCARD: 0x00.
- Free counts are truncated or zero-extended to 8 bits in tx_byte.
- Error flags are sticky. A set event coincident with CLEAR_ERRORS wins: that bit stays 1.

## Timing

- Reset (rst_n=0, asynchronous), all outputs and state go to:
  - state IDLE, bc=0, idx=0.
  - tx_byte=0x00, error_flags=0x00.
  - fifo_wr_en=0, fifo_flush=0.
  - fifo_wr_data=0.
- Reset mid-frame drops any partial record without setting PARTIAL.
- fifo_wr_en and fifo_flush: registered, asserted exactly one cycle, in the cycle after the triggering rx_valid.
- fifo_wr_data stays stable until the next record's first byte arrives.
- tx_byte latency: reflects a new state or idx one cycle after rx_valid, and reflects a changed fifo_free one cycle later.
- Back-to-back rx_valid on consecutive cycles must be accepted in every state.
- Writes to a FIFO are at least RecordBytes rx_valids apart, so fifo_free is always current when sampled.
- error_flags: updated one cycle after the causing event.

## Test plan

- **Reset/status:** rst_n low, release; Channels=4, fifo_free={3,7,16,16} (ch0=16).
  - After release, tx_byte=0x10.
  - Frame 0x00 + 6 dummy bytes → tx sequence 0x10,0x10,0x07,0x03,0x00(err),0x00.
- **Write two records:** frame 0x12 + 24 bytes 0x00..0x17, RecordBytes=12, free ch2=5.
  - fifo_wr_en=4'b0100 twice.
  - First record: data byte0=0x00, byte11=0x0B.
  - Second record: byte0=0x0C.
  - error_flags=0.
- **Overflow:** frame 0x11 + 12 bytes with fifo_free ch1=0 → no fifo_wr_en; error_flags=0x01.
- **Partial frame:** frame 0x10 + 5 bytes, then spi_cs=1 → no write; error_flags bit1=1.
  - Next frame 0x00: the byte at idx=Channels reads 0x02 (plus any earlier bits).
- **Bad command / flush / clear:**
  - 0x14 with Channels=4 → BAD_CMD set (0x04), no strobes.
  - 0x23 → fifo_flush=4'b1000 for one cycle.
  - 0x30 → error_flags=0x00 one cycle after the byte.
- **cs overrides rx_valid:** rx_valid and spi_cs=1 in the same cycle during RECEIVE with bc=11 → no write, PARTIAL set, state IDLE.
